// File: rtl/fifo_serial_writer_if.sv
// fifo_serial_writer_if: push/data/full link between the serial writer and the FIFO write port
interface fifo_serial_writer_if #(parameter int M = 2);
  logic         push;
  logic [M-1:0] data;
  logic         full;
  modport master (output push, data, input full);
  modport slave  (input push, data, output full);
endinterface

// File: rtl/fifo_serial_writer.sv
// fifo_serial_writer: UART-style frame receiver that pushes each completed word into a FIFO, dropping and counting words while full
module fifo_serial_writer #(
  parameter int M   = 2,
  parameter int DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic                   clr,
  fifo_serial_writer_if.master   fifo,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);
  localparam int CW = $clog2(DIV) + 1;
  localparam int BW = $clog2(M) + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [M-1:0]    sh_q, sh_d, data_q, data_d;
  logic            push_q, push_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;
  logic            tick_half, tick_full;
  assign tick_half = cnt_q == CW'(DIV / 2 - 1);
  assign tick_full = cnt_q == CW'(DIV - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx) state_d = START;
      end
      START: if (tick_half) begin
        cnt_d   = '0;
        state_d = rx ? IDLE : DATA;
      end
      DATA: if (tick_full) begin
        cnt_d = '0;
        sh_d  = {rx, sh_q[M-1:1]};
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(M - 1)) state_d = STOP;
      end
      default: if (tick_full) begin
        cnt_d   = '0;
        state_d = IDLE;
        if (!rx) ferr_d = 1'b1;
        else if (fifo.full) begin
          ovf_d  = 1'b1;
          drop_d = (drop_q == 8'hff) ? drop_q : drop_q + 8'd1;
        end else begin
          data_d = sh_q;
          push_d = 1'b1;
        end
      end
    endcase
    // clear beats a drop landing on the same edge
    if (clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end
  assign fifo.push = push_q;
  assign fifo.data = data_q;
  assign busy      = state_q != IDLE;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_fifo_serial_writer.sv
// tb_fifo_serial_writer: directed frames against the serial writer with a small 4-deep FIFO model on its write port
module tb_fifo_serial_writer;
  localparam int M = 2;
  localparam int DIV = 4;
  localparam int FL = (M + 2) * DIV;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic clr = 1'b0;
  logic force_full = 1'b0;
  logic busy, frame_err, overflow;
  logic [7:0] drop_cnt;
  int checks = 0;
  int errors = 0;
  int npush = 0;
  int npop = 0;
  int nferr = 0;
  logic [M-1:0] fq[$];
  fifo_serial_writer_if #(.M(M)) fif ();
  assign fif.full = force_full | ((npush - npop) >= 4);
  fifo_serial_writer #(.M(M), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .rx(rx), .clr(clr), .fifo(fif),
    .busy(busy), .frame_err(frame_err), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (fif.push) begin
      npush++;
      fq.push_back(fif.data);
    end
    if (frame_err) nferr++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic bitv(input int i, input logic [M-1:0] w, input logic stopb);
    return (i < DIV) ? 1'b0 : (i < (M + 1) * DIV) ? w[(i - DIV) / DIV] : stopb;
  endfunction
  task automatic send(input logic [M-1:0] w, input logic stopb);
    for (int i = 0; i < FL; i++) begin
      rx = bitv(i, w, stopb);
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask
  initial begin
    int p0, e0;
    logic [M-1:0] exp_q[4];
    logic [M-1:0] got;
    exp_q = '{2'b01, 2'b11, 2'b00, 2'b10};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_push_cnt", npush, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ferr_cnt", nferr, 0);
    chk("idle_overflow", overflow, 0);
    chk("idle_drop_cnt", drop_cnt, 0);
    chk("idle_data", fif.data, 0);
    for (int i = 0; i < FL; i++) begin
      rx = bitv(i, 2'b10, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("w10_push_e%0d", i), fif.push, i == 14);
      chk($sformatf("w10_busy_e%0d", i), busy, i < 14);
    end
    rx = 1'b1;
    chk("w10_data", fif.data, 2'b10);
    chk("w10_push_cnt", npush, 1);
    fq.delete();
    npop = npush;
    p0 = npush;
    for (int k = 0; k < 4; k++) send(exp_q[k], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_push_cnt", npush - p0, 4);
    chk("b2b_full", fif.full, 1);
    chk("b2b_data", fif.data, 2'b10);
    for (int k = 0; k < 3; k++) send(2'b01, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_push_cnt", npush - p0, 4);
    chk("drop_overflow", overflow, 1);
    chk("drop_cnt3", drop_cnt, 3);
    chk("drop_data", fif.data, 2'b10);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    for (int k = 0; k < 260; k++) send(2'b11, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_drop_cnt", drop_cnt, 255);
    chk("sat_overflow", overflow, 1);
    chk("sat_push_cnt", npush - p0, 4);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr2_drop_cnt", drop_cnt, 0);
    for (int k = 0; k < 4; k++) begin
      got = fq.pop_front();
      npop++;
      chk($sformatf("pop%0d", k), got, exp_q[k]);
    end
    #1;
    chk("pop_full", fif.full, 0);
    p0 = npush;
    e0 = nferr;
    send(2'b01, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("ferr_cnt", nferr - e0, 1);
    chk("ferr_push_cnt", npush - p0, 0);
    chk("ferr_data", fif.data, 2'b10);
    chk("ferr_drop_cnt", drop_cnt, 0);
    rx = 1'b0;
    @(posedge clk);
    #1 rx = 1'b1;
    chk("glitch_busy_hi", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_ferr_cnt", nferr - e0, 1);
    chk("glitch_push_cnt", npush - p0, 0);
    for (int i = 0; i < 10; i++) begin
      rx = bitv(i, 2'b11, 1'b1);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (FL) @(posedge clk);
    #1;
    chk("rst_push_cnt", npush - p0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", fif.data, 0);
    chk("rst_ferr_cnt", nferr - e0, 1);
    send(2'b11, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_push_cnt", npush - p0, 1);
    chk("post_rst_data", fif.data, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
